sata_cmd_sequencer: RTL and testbench
=====================================

// Module: sata_cmd_sequencer
// PURPOSE
//  Sequences one ATA command at a time onto the SATA core's host shadow-register port.
//  Accepts a command (opcode, 48-bit LBA, 16-bit count) via valid/ready.
//  Writes the shadow registers, waits for interrupt-pending, reads status and reports completion/error.
//  Sits between user command logic and the SATA top's HOST_* / CE / IPF interface, on the link/transport clock.
// PARAMETERS
//  ADDR_LBA_LO   5'h01        shadow addr: {8'h00, lba[23:0]}
//  ADDR_LBA_HI   5'h02        shadow addr: {8'h00, lba[47:24]}
//  ADDR_COUNT    5'h03        shadow addr: {16'h0, count}
//  ADDR_DEVICE   5'h04        shadow addr: {24'h0, DEVICE_VAL}
//  ADDR_CMD      5'h05        shadow addr: {24'h0, opcode}; this write launches the command
//  ADDR_STATUS   5'h07        shadow addr read for status byte [7:0]
//  DEVICE_VAL    8'h40        device register value (LBA mode)
//  RD_LATENCY    1            cycles from host_read_en to valid host_data_out (1..3)
//  TIMEOUT       32'd75000000 cycles allowed in WAIT_IPF before timeout (1 s at 75 MHz)
// PORTS
//  clk            in   1   link/transport clock (CLK_OUT of SATA top)
//  reset          in   1   synchronous, active-high
//  linkup         in   1   PHY link up
//  cmd_valid      in   1   command request
//  cmd_ready      out  1   sequencer can accept command
//  cmd_opcode     in   8   ATA command opcode
//  cmd_lba        in   48  start LBA
//  cmd_count      in   16  sector count
//  abort          in   1   single-cycle pulse: abandon current command
//  host_write_en  out  1   to HOST_WRITE_EN
//  host_read_en   out  1   to HOST_READ_EN
//  host_addr      out  5   to HOST_ADDR_REG
//  host_data_in   out  32  to HOST_DATA_IN
//  host_data_out  in   32  from HOST_DATA_OUT
//  ce             out  1   to CE; high from first write to done
//  ipf            in   1   interrupt pending flag
//  r_err          in   1   R_ERR from link
//  illegal_state  in   1   ILLEGAL_STATE from link
//  busy           out  1   state != IDLE
//  done           out  1   one-cycle completion pulse
//  status         out  8   status byte captured at done (held until next done)
//  err_code       out  3   0 OK,1 DEV_ERR,2 TIMEOUT,3 R_ERR,4 ILLEGAL,5 LINK_LOST,6 ABORT; held with status
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready (=linkup, combinational in IDLE); timer/sticky flags cleared.
//  cmd_ready = (state==IDLE) & linkup. Handshake on cmd_valid&cmd_ready: opcode/lba/count registered.
//  IDLE -> WR(0) on handshake. WR(i), i=0..4: one cycle each; host_write_en=1, host_addr/host_data_in
//   per table order LBA_LO, LBA_HI, COUNT, DEVICE, CMD; 5 back-to-back write cycles; ce=1.
//  WR(4) -> WAIT_IPF; timer cleared to 0, increments each cycle in WAIT_IPF.
//  WAIT_IPF: ipf=1 -> RD; timer==TIMEOUT-1 and ipf=0 -> DONE, err TIMEOUT, status 8'h00. ipf wins on tie.
//  RD: host_read_en=1 for one cycle, host_addr=ADDR_STATUS -> RD_WAIT.
//  RD_WAIT: capture host_data_out[7:0] exactly RD_LATENCY cycles after the RD cycle -> DONE.
//  Sticky flags: r_err/illegal_state sampled high in any non-IDLE state set flags; cleared on handshake.
//  err_code at DONE, priority: ABORT > LINK_LOST > TIMEOUT > ILLEGAL > R_ERR > DEV_ERR(status[0]) > OK.
//  DONE: done=1 one cycle, status/err_code updated same cycle, ce drops -> IDLE next cycle.
//  abort in any non-IDLE/non-DONE state -> DONE next cycle with ABORT; ignored in IDLE and DONE.
//  linkup=0 in any non-IDLE/non-DONE state -> DONE with LINK_LOST (unless abort same cycle).
//  No new command accepted until IDLE; cmd_valid in DONE cycle is not accepted.
//  reset mid-operation: immediate return to IDLE, no done pulse, host_*_en deasserted same edge.
// TESTING
//  1 cmd 8'h25, lba 48'h0000_1234_5678, count 16'h0008; ipf after 20 cyc, status 8'h50 -> 5 writes
//    data 32'h0034_5678, 32'h0000_0012, 32'h0000_0008, 32'h0000_0040, 32'h0000_0025; done, err 0, status 8'h50.
//  2 TIMEOUT=100, ipf never -> done exactly 100 cycles after WAIT_IPF entry, err_code 2, status 8'h00.
//  3 status read returns 8'h51 with r_err pulsed during WAIT_IPF -> err_code 3 (R_ERR beats DEV_ERR).
//  4 abort and linkup drop in the same WAIT_IPF cycle -> err_code 6 next cycle; cmd_ready stays 0 while linkup=0.
//  5 reset asserted during WR(2) -> next cycle IDLE, host_write_en=0, no done; fresh command completes OK.
//  6 RD_LATENCY=3: host_data_out valid only 3 cycles after read -> status captured from that cycle only.

Source files
------------

// File: rtl/sata_cmd_sequencer.sv
// Issues one ATA command at a time through the SATA host shadow-register port.
// It writes the command registers, waits for IPF, reads the status byte and reports completion.
module sata_cmd_sequencer #(
    parameter logic [4:0]  ADDR_LBA_LO = 5'h01,
    parameter logic [4:0]  ADDR_LBA_HI = 5'h02,
    parameter logic [4:0]  ADDR_COUNT  = 5'h03,
    parameter logic [4:0]  ADDR_DEVICE = 5'h04,
    parameter logic [4:0]  ADDR_CMD    = 5'h05,
    parameter logic [4:0]  ADDR_STATUS = 5'h07,
    parameter logic [7:0]  DEVICE_VAL  = 8'h40,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned TIMEOUT     = 32'd75000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_linkup,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_cmd_opcode,
    input  logic [47:0] i_cmd_lba,
    input  logic [15:0] i_cmd_count,
    input  logic        i_abort,
    output logic        o_host_write_en,
    output logic        o_host_read_en,
    output logic [4:0]  o_host_addr,
    output logic [31:0] o_host_data_in,
    input  logic [31:0] i_host_data_out,
    output logic        o_ce,
    input  logic        i_ipf,
    input  logic        i_r_err,
    input  logic        i_illegal_state,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_status,
    output logic [2:0]  o_err_code
);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_DEV     = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_R_ERR   = 3'd3;
    localparam logic [2:0] ERR_ILLEGAL = 3'd4;
    localparam logic [2:0] ERR_LINK    = 3'd5;
    localparam logic [2:0] ERR_ABORT   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WAIT_IPF, S_RD, S_RD_WAIT, S_DONE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_wr_idx;
    logic [31:0] r_timer;
    logic [1:0]  r_lat;
    logic        r_rerr_flag;
    logic        r_ill_flag;
    logic [7:0]  r_opcode;
    logic [47:0] r_lba;
    logic [15:0] r_count;
    logic        r_write_en;
    logic        r_read_en;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic        r_ce;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_status;
    logic [2:0]  r_err_code;

    logic        w_active;
    logic        w_fin;
    logic [7:0]  w_fin_status;
    logic [2:0]  w_fin_err;
    logic        w_unused_data;

    // Address and data of write slot idx: LBA_LO, LBA_HI, COUNT, DEVICE, then the launching CMD
    function automatic logic [36:0] wr_word(input logic [2:0] idx, input logic [7:0] op,
                                            input logic [47:0] lba, input logic [15:0] cnt);
        case (idx)
            3'd0:    return {ADDR_LBA_LO, 8'h00, lba[23:0]};
            3'd1:    return {ADDR_LBA_HI, 8'h00, lba[47:24]};
            3'd2:    return {ADDR_COUNT, 16'h0000, cnt};
            3'd3:    return {ADDR_DEVICE, 24'h000000, DEVICE_VAL};
            default: return {ADDR_CMD, 24'h000000, op};
        endcase
    endfunction

    assign o_cmd_ready     = (r_state == S_IDLE) & i_linkup;
    assign o_host_write_en = r_write_en;
    assign o_host_read_en  = r_read_en;
    assign o_host_addr     = r_addr;
    assign o_host_data_in  = r_data;
    assign o_ce            = r_ce;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_status        = r_status;
    assign o_err_code      = r_err_code;
    assign w_unused_data   = ^i_host_data_out[31:8];

    // Decide whether this cycle ends the command, and with which status / error code
    always_comb begin
        w_fin        = 1'b0;
        w_fin_status = 8'h00;
        w_fin_err    = ERR_OK;
        w_active     = (r_state == S_WR) || (r_state == S_WAIT_IPF) ||
                       (r_state == S_RD) || (r_state == S_RD_WAIT);
        if (w_active && i_abort) begin
            w_fin     = 1'b1;
            w_fin_err = ERR_ABORT;
        end else if (w_active && !i_linkup) begin
            w_fin     = 1'b1;
            w_fin_err = ERR_LINK;
        end else if (r_state == S_WAIT_IPF && !i_ipf && r_timer == 32'(TIMEOUT - 1)) begin
            w_fin     = 1'b1;
            w_fin_err = ERR_TIMEOUT;
        end else if (r_state == S_RD_WAIT && r_lat == 2'(RD_LATENCY)) begin
            w_fin        = 1'b1;
            w_fin_status = i_host_data_out[7:0];
            if (r_ill_flag || i_illegal_state)  w_fin_err = ERR_ILLEGAL;
            else if (r_rerr_flag || i_r_err)    w_fin_err = ERR_R_ERR;
            else if (i_host_data_out[0])        w_fin_err = ERR_DEV;
            else                                w_fin_err = ERR_OK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_wr_idx    <= 3'd0;
            r_timer     <= 32'd0;
            r_lat       <= 2'd0;
            r_rerr_flag <= 1'b0;
            r_ill_flag  <= 1'b0;
            r_opcode    <= 8'h00;
            r_lba       <= 48'h0;
            r_count     <= 16'h0000;
            r_write_en  <= 1'b0;
            r_read_en   <= 1'b0;
            r_addr      <= 5'h00;
            r_data      <= 32'h0;
            r_ce        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= 8'h00;
            r_err_code  <= ERR_OK;
        end else begin
            r_write_en <= 1'b0;
            r_read_en  <= 1'b0;
            r_done     <= 1'b0;
            if (r_state != S_IDLE) begin
                if (i_r_err)         r_rerr_flag <= 1'b1;
                if (i_illegal_state) r_ill_flag  <= 1'b1;
            end
            if (w_fin) begin
                r_state    <= S_DONE;
                r_done     <= 1'b1;
                r_ce       <= 1'b0;
                r_status   <= w_fin_status;
                r_err_code <= w_fin_err;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_cmd_valid && o_cmd_ready) begin
                            r_opcode          <= i_cmd_opcode;
                            r_lba             <= i_cmd_lba;
                            r_count           <= i_cmd_count;
                            r_rerr_flag       <= 1'b0;
                            r_ill_flag        <= 1'b0;
                            r_wr_idx          <= 3'd0;
                            r_write_en        <= 1'b1;
                            {r_addr, r_data}  <= wr_word(3'd0, i_cmd_opcode, i_cmd_lba, i_cmd_count);
                            r_ce              <= 1'b1;
                            r_busy            <= 1'b1;
                            r_state           <= S_WR;
                        end
                    end
                    S_WR: begin
                        if (r_wr_idx == 3'd4) begin
                            r_timer <= 32'd0;
                            r_state <= S_WAIT_IPF;
                        end else begin
                            r_wr_idx         <= r_wr_idx + 3'd1;
                            r_write_en       <= 1'b1;
                            {r_addr, r_data} <= wr_word(r_wr_idx + 3'd1, r_opcode, r_lba, r_count);
                        end
                    end
                    S_WAIT_IPF: begin
                        if (i_ipf) begin
                            r_read_en <= 1'b1;
                            r_addr    <= ADDR_STATUS;
                            r_state   <= S_RD;
                        end else begin
                            r_timer <= r_timer + 32'd1;
                        end
                    end
                    S_RD: begin
                        r_lat   <= 2'd1;
                        r_state <= S_RD_WAIT;
                    end
                    S_RD_WAIT: r_lat <= r_lat + 2'd1;
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sata_cmd_sequencer.sv
// Directed bench for sata_cmd_sequencer: a per-command expected-output timeline is derived
// from the command schedule and compared against the DUT every cycle.
module tb_sata_cmd_sequencer;

    localparam int unsigned T = 100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset[2], linkup[2], cmd_valid[2], cmd_ready[2], abort_p[2];
    logic [7:0]  opcode[2];
    logic [47:0] lba[2];
    logic [15:0] count[2];
    logic        we[2], re[2], ce[2], ipf[2], r_err[2], ill[2], busy[2], done[2];
    logic [4:0]  addr[2];
    logic [31:0] din[2], dout[2];
    logic [7:0]  status[2];
    logic [2:0]  err[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sata_cmd_sequencer #(.TIMEOUT(T), .RD_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .i_clk(clk), .i_reset(reset[g]), .i_linkup(linkup[g]),
            .i_cmd_valid(cmd_valid[g]), .o_cmd_ready(cmd_ready[g]),
            .i_cmd_opcode(opcode[g]), .i_cmd_lba(lba[g]), .i_cmd_count(count[g]),
            .i_abort(abort_p[g]), .o_host_write_en(we[g]), .o_host_read_en(re[g]),
            .o_host_addr(addr[g]), .o_host_data_in(din[g]), .i_host_data_out(dout[g]),
            .o_ce(ce[g]), .i_ipf(ipf[g]), .i_r_err(r_err[g]), .i_illegal_state(ill[g]),
            .o_busy(busy[g]), .o_done(done[g]), .o_status(status[g]), .o_err_code(err[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle, published by the stimulus task
    logic        exp_chk = 1'b0;
    int          exp_g = 0;
    logic        exp_we, exp_re, exp_ce, exp_busy, exp_done, exp_ready;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [7:0]  m_status[2];
    logic [2:0]  m_err[2];
    logic [31:0] wr_log[$];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [36:0] exp_word(input int i, input logic [7:0] op,
                                             input logic [47:0] l, input logic [15:0] cn);
        case (i)
            0:       return {5'h01, 8'h00, l[23:0]};
            1:       return {5'h02, 8'h00, l[47:24]};
            2:       return {5'h03, 16'h0000, cn};
            3:       return {5'h04, 24'h000000, 8'h40};
            default: return {5'h05, 24'h000000, op};
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_chk) begin
            check("cmd_ready", 48'(cmd_ready[exp_g]), 48'(exp_ready));
            check("write_en", 48'(we[exp_g]), 48'(exp_we));
            check("read_en", 48'(re[exp_g]), 48'(exp_re));
            check("ce", 48'(ce[exp_g]), 48'(exp_ce));
            check("busy", 48'(busy[exp_g]), 48'(exp_busy));
            check("done", 48'(done[exp_g]), 48'(exp_done));
            check("status", 48'(status[exp_g]), 48'(m_status[exp_g]));
            check("err_code", 48'(err[exp_g]), 48'(m_err[exp_g]));
            if (exp_we || exp_re) check("host_addr", 48'(addr[exp_g]), 48'(exp_addr));
            if (exp_we)           check("host_data", 48'(din[exp_g]), 48'(exp_data));
            if (we[exp_g]) wr_log.push_back(din[exp_g]);
        end
    end

    // Cycle 0 = handshake cycle, 1..5 = writes, 6+k = k-th WAIT_IPF cycle.
    // Offsets (*_at) are relative to WAIT_IPF entry; -1 means never.
    task automatic run(input int g, input logic [7:0] op, input logic [47:0] l,
                       input logic [15:0] cn, input int ipf_at, input logic [7:0] st,
                       input int rerr_at, input int ill_at, input int abort_at,
                       input int link_at, input int rst_at, input int tail,
                       output int d_cyc);
        int lat, end_off, cause, rd_c, data_c, last, e_err;
        logic [7:0] e_st;
        logic post_rst;
        lat     = (g == 0) ? 1 : 3;
        end_off = int'(T) - 1;
        cause   = 2;
        if (ipf_at >= 0 && ipf_at <= end_off)     begin end_off = ipf_at;   cause = 0; end
        if (link_at >= 0 && link_at <= end_off)   begin end_off = link_at;  cause = 5; end
        if (abort_at >= 0 && abort_at <= end_off) begin end_off = abort_at; cause = 6; end
        rd_c = -1; data_c = -1;
        if (cause == 0) begin
            rd_c   = 7 + end_off;
            data_c = rd_c + lat;
            d_cyc  = data_c + 1;
        end else begin
            d_cyc  = 7 + end_off;
        end
        e_st  = (cause == 0) ? st : 8'h00;
        if (cause != 0)        e_err = cause;
        else if (ill_at >= 0)  e_err = 4;
        else if (rerr_at >= 0) e_err = 3;
        else if (st[0])        e_err = 1;
        else                   e_err = 0;
        last = (rst_at >= 0) ? rst_at + 4 : d_cyc + 1 + tail;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            post_rst     = (rst_at >= 0) && (c > rst_at);
            cmd_valid[g] = !post_rst && ((c == 0) || (c == d_cyc));
            opcode[g] = op; lba[g] = l; count[g] = cn;
            ipf[g]     = (ipf_at >= 0) && (c == 6 + ipf_at);
            r_err[g]   = (rerr_at >= 0) && (c == 6 + rerr_at);
            ill[g]     = (ill_at >= 0) && (c == 6 + ill_at);
            abort_p[g] = (abort_at >= 0) && (c == 6 + abort_at);
            linkup[g]  = !((link_at >= 0) && (c >= 6 + link_at));
            reset[g]   = (c == rst_at);
            dout[g]    = (c == data_c) ? {24'hC0FFEE, st} : 32'h1234_56EE;
            if (post_rst) begin
                if (c == rst_at + 1) begin m_status[g] = 8'h00; m_err[g] = 3'd0; end
                exp_we = 0; exp_re = 0; exp_ce = 0; exp_busy = 0; exp_done = 0;
                exp_addr = 5'h00; exp_data = 32'h0;
                exp_ready = linkup[g];
            end else begin
                exp_we = (c >= 1) && (c <= 5);
                {exp_addr, exp_data} = exp_word(c - 1, op, l, cn);
                exp_re = (c == rd_c);
                if (exp_re) exp_addr = 5'h07;
                exp_ce    = (c >= 1) && (c < d_cyc);
                exp_busy  = (c >= 1) && (c <= d_cyc);
                exp_done  = (c == d_cyc);
                exp_ready = !exp_busy && linkup[g];
                if (exp_done) begin m_status[g] = e_st; m_err[g] = 3'(e_err); end
            end
            exp_g   = g;
            exp_chk = 1'b1;
        end
        @(posedge clk); #1;
        exp_chk = 1'b0;
        cmd_valid[g] = 0; ipf[g] = 0; r_err[g] = 0; ill[g] = 0; abort_p[g] = 0;
        linkup[g] = 1; reset[g] = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int d;
        logic [31:0] exp_wr[5];
        for (int g = 0; g < 2; g++) begin
            reset[g] = 1; linkup[g] = 1; cmd_valid[g] = 0; abort_p[g] = 0;
            opcode[g] = 0; lba[g] = 0; count[g] = 0; ipf[g] = 0; r_err[g] = 0;
            ill[g] = 0; dout[g] = 0; m_status[g] = 0; m_err[g] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 48'(cmd_ready[0]), 48'd1);
        check("reset_we", 48'(we[0]), 48'd0);
        check("reset_busy", 48'(busy[0]), 48'd0);
        check("reset_ce", 48'(ce[0]), 48'd0);
        check("reset_status", 48'(status[0]), 48'd0);
        linkup[0] = 0; #1;
        check("ready_no_link", 48'(cmd_ready[0]), 48'd0);
        linkup[0] = 1;
        reset[0] = 0; reset[1] = 0;
        @(posedge clk); #1;

        // 1: normal command
        wr_log.delete();
        run(0, 8'h25, 48'h0000_1234_5678, 16'h0008, 20, 8'h50, -1, -1, -1, -1, -1, 0, d);
        check("t1_done_cycle", 48'(d), 48'd29);
        exp_wr = '{32'h0034_5678, 32'h0000_0012, 32'h0000_0008, 32'h0000_0040, 32'h0000_0025};
        check("t1_nwrites", 48'(wr_log.size()), 48'd5);
        for (int i = 0; i < 5; i++)
            check("t1_wr_data", 48'((wr_log.size() > i) ? wr_log[i] : 32'hX), 48'(exp_wr[i]));
        check("t1_status", 48'(status[0]), 48'h50);
        check("t1_err", 48'(err[0]), 48'd0);

        // 2: timeout
        run(0, 8'hC8, 48'h0000_0000_0100, 16'h0001, -1, 8'h00, -1, -1, -1, -1, -1, 0, d);
        check("t2_done_cycle", 48'(d), 48'd106);
        check("t2_err", 48'(err[0]), 48'd2);

        // 3: r_err beats DEV_ERR; then plain DEV_ERR; then ILLEGAL beats R_ERR
        run(0, 8'h35, 48'hABCD_EF01_2345, 16'hFFFF, 10, 8'h51, 3, -1, -1, -1, -1, 0, d);
        check("t3_err", 48'(err[0]), 48'd3);
        run(0, 8'h35, 48'h0000_0000_0001, 16'h0002, 4, 8'h51, -1, -1, -1, -1, -1, 0, d);
        check("t3_dev_err", 48'(err[0]), 48'd1);
        run(0, 8'h25, 48'h0000_0000_0002, 16'h0003, 8, 8'h50, 5, 2, -1, -1, -1, 0, d);
        check("t3_illegal", 48'(err[0]), 48'd4);

        // 4: abort + link drop same cycle, link held low in the tail; then link loss alone
        run(0, 8'h25, 48'h0000_0000_0003, 16'h0004, -1, 8'h00, -1, -1, 5, 5, -1, 3, d);
        check("t4_done_cycle", 48'(d), 48'd12);
        check("t4_err", 48'(err[0]), 48'd6);
        run(0, 8'h25, 48'h0000_0000_0004, 16'h0005, -1, 8'h00, -1, -1, -1, 4, -1, 2, d);
        check("t4_link_err", 48'(err[0]), 48'd5);

        // ipf on the final timer cycle wins over timeout
        run(0, 8'h25, 48'h0000_0000_0005, 16'h0006, 99, 8'h40, -1, -1, -1, -1, -1, 0, d);
        check("tie_done_cycle", 48'(d), 48'd108);
        check("tie_err", 48'(err[0]), 48'd0);

        // 5: reset during WR(2), then a fresh command
        run(0, 8'h25, 48'h0000_0000_0006, 16'h0007, 2, 8'h50, -1, -1, -1, -1, 3, 0, d);
        check("t5_status_cleared", 48'(status[0]), 48'h0);
        run(0, 8'h24, 48'h0000_0000_0007, 16'h0008, 2, 8'h50, -1, -1, -1, -1, -1, 0, d);
        check("t5_fresh_err", 48'(err[0]), 48'd0);

        // 6: read latency 3
        run(1, 8'h25, 48'h0000_1234_5678, 16'h0008, 5, 8'h50, -1, -1, -1, -1, -1, 0, d);
        check("t6_done_cycle", 48'(d), 48'd16);
        check("t6_status", 48'(status[1]), 48'h50);
        check("t6_err", 48'(err[1]), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
